// File: rtl/banner_pkg.sv
// Shared constants for the scrolling seven-segment banner: active-low segment
// codes, the circular message ROM and divider sizing helpers.
package banner_pkg;

  localparam int unsigned MSG_LEN   = 8;
  localparam int unsigned NUM_DIGIT = 4;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
    SEG_H, SEG_O, SEG_L, SEG_A, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

  function automatic int unsigned cnt_width(input int unsigned div);
    if (div <= 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(div);
    end
  endfunction

  function automatic logic [7:0] msg_at(input logic [2:0] idx);
    logic [7:0] code;
    case (idx)
      3'd0:    code = SEG_H;
      3'd1:    code = SEG_O;
      3'd2:    code = SEG_L;
      3'd3:    code = SEG_A;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] anode_of(input logic [1:0] sel);
    logic [3:0] an;
    case (sel)
      2'd0:    an = 4'b1110;
      2'd1:    an = 4'b1101;
      2'd2:    an = 4'b1011;
      2'd3:    an = 4'b0111;
      default: an = 4'b1111;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-DIV counter; tick is high in the cycle the counter
// holds DIV-1, and is held high when DIV is 1.
module tick_gen
  import banner_pkg::*;
#(
  parameter int unsigned DIV = 32'd2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W    = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 32'd1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count and terminal decode.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/banner_ctrl.sv
// Four-digit multiplexed seven-segment banner that scrolls an 8-entry
// circular message left at SHIFT_FREQ while scanning digits at SCAN_FREQ.
module banner_ctrl
  import banner_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32'd50_000_000,
  parameter int unsigned SCAN_FREQ  = 32'd1_000,
  parameter int unsigned SHIFT_FREQ = 32'd2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] anodos,
  output logic [7:0] segmentos,
  output logic       shift
);

  localparam int unsigned SCAN_DIV  = CLK_FREQ / SCAN_FREQ;
  localparam int unsigned SHIFT_DIV = CLK_FREQ / SHIFT_FREQ;

  logic       scan_tick_s;
  logic       shift_tick_s;
  logic [1:0] sel_q;
  logic [1:0] sel_d;
  logic [2:0] ptr_q;
  logic [2:0] ptr_d;
  logic [2:0] idx_s;

  tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick_s)
  );

  tick_gen #(.DIV(SHIFT_DIV)) u_shift_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (shift_tick_s)
  );

  // Digit select and message pointer next-state; both events may land together.
  always_comb begin
    sel_d = sel_q;
    ptr_d = ptr_q;
    if (scan_tick_s) begin
      sel_d = sel_q + 2'd1;
    end else begin
      sel_d = sel_q;
    end
    if (shift_tick_s) begin
      ptr_d = ptr_q + 3'd1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Display state registers; reset overrides any pending event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 2'd0;
      ptr_q <= 3'd0;
    end else begin
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end

  // Leftmost digit (sel 3) shows ROM[ptr], rightmost (sel 0) shows ROM[ptr+3].
  always_comb begin
    idx_s     = ptr_q + 3'd3 - {1'b0, sel_q};
    anodos    = anode_of(sel_q);
    segmentos = msg_at(idx_s);
    shift     = shift_tick_s;
  end

endmodule

// File: tb/tb_banner_ctrl.sv
// Scoreboarded random-reset bench for banner_ctrl with a cycle-count model.
module tb_banner_ctrl;

  localparam int unsigned SCAN_DIV  = 10;
  localparam int unsigned SHIFT_DIV = 120;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       sh;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] anodos;
  logic [7:0] segmentos;
  logic       shift;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  bit   drive_done;

  logic [7:0] rom [8] = '{8'h89, 8'hC0, 8'hC7, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  banner_ctrl #(
    .CLK_FREQ   (600),
    .SCAN_FREQ  (60),
    .SHIFT_FREQ (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .anodos    (anodos),
    .segmentos (segmentos),
    .shift     (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the t-th cycle after reset released.
  function automatic exp_t model(input int t);
    exp_t e;
    int   digit;
    int   scroll;
    int   pos;
    digit  = (t / SCAN_DIV) % 4;
    scroll = (t / SHIFT_DIV) % 8;
    pos    = 3 - digit;            // 0 = leftmost digit
    e.an   = 4'b1111;
    e.an[digit] = 1'b0;
    e.seg  = rom[(scroll + pos) % 8];
    e.sh   = ((t % SHIFT_DIV) == SHIFT_DIV - 1);
    return e;
  endfunction

  // Driver: decides rst per edge and pushes the expected post-edge outputs.
  initial begin
    int t;
    int rst_left;
    t          = 0;
    rst_left   = 0;
    drive_done = 1'b0;
    rst        = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (rst) t = 0;
      else     t = t + 1;
      exp_q.push_back(model(t));
      #1;
      if (c < 2) begin
        rst = 1'b1;
      end else if (c == 2 + 1000) begin
        rst = 1'b1;
      end else if (c > 1100 && rst_left == 0 && $urandom_range(0, 399) == 0) begin
        rst_left = $urandom_range(1, 3);
        rst = 1'b1;
      end else if (rst_left > 0) begin
        rst_left = rst_left - 1;
        rst = (rst_left > 0);
      end else begin
        rst = 1'b0;
      end
    end
    drive_done = 1'b1;
  end

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors = vectors + 1;
      if (anodos !== e.an) begin
        miscompares = miscompares + 1;
        $display("FAIL anodos vec=%0d got=%b exp=%b", vectors, anodos, e.an);
      end
      if (segmentos !== e.seg) begin
        miscompares = miscompares + 1;
        $display("FAIL segmentos vec=%0d got=%h exp=%h", vectors, segmentos, e.seg);
      end
      if (shift !== e.sh) begin
        miscompares = miscompares + 1;
        $display("FAIL shift vec=%0d got=%b exp=%b", vectors, shift, e.sh);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    wait (drive_done);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    if (vectors < 12) begin
      miscompares = miscompares + 1;
      $display("FAIL count got=%0d exp>=12", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/banner_ctrl.md
BANNER_CTRL -- requirements
Module: banner

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter SCAN_FREQ, default 1_000, digit-advance rate in Hz; SCAN_DIV = CLK_FREQ/SCAN_FREQ (integer division), SHALL be >= 1.
REQ-003 Parameter SHIFT_FREQ, default 2, text-scroll rate in Hz; SHIFT_DIV = CLK_FREQ/SHIFT_FREQ (integer division), SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 anodos  output  4  digit enables, active-low one-hot; bit 3 = leftmost digit, bit 0 = rightmost.
REQ-007 segmentos  output  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.
REQ-008 shift  output  1  one-cycle pulse marking each scroll step.

Function
REQ-009 The message SHALL be an 8-entry circular ROM: idx0 'H' = 0x89, idx1 'O' = 0xC0, idx2 'L' = 0xC7, idx3 'A' = 0x88, idx4-7 blank = 0xFF (active-low codes, dp always off).
REQ-010 State SHALL be: scan counter (0..SCAN_DIV-1), shift counter (0..SHIFT_DIV-1), 2-bit digit select sel, 3-bit message pointer ptr.
REQ-011 Each counter SHALL increment every cycle and wrap to 0 after its maximum value.
REQ-012 When the scan counter equals SCAN_DIV-1, sel SHALL increment modulo 4 (0->1->2->3->0) at that clock edge.
REQ-013 shift SHALL be 1 exactly in cycles where the shift counter equals SHIFT_DIV-1, otherwise 0; it is decoded combinationally from the counter.
REQ-014 In a cycle where shift = 1, ptr SHALL increment modulo 8 at the clock edge ending that cycle, scrolling the text left.
REQ-015 anodos SHALL equal ~(4'b0001 << sel): sel 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-016 segmentos SHALL equal ROM[(ptr + 3 - sel) mod 8]: leftmost digit shows ROM[ptr], rightmost shows ROM[ptr+3].
REQ-017 anodos and segmentos SHALL be combinational decodes of registered sel and ptr, so a digit and its segment pattern change in the same cycle.
REQ-018 Scan and shift events in the same cycle SHALL both take effect at that edge; the new ptr and new sel SHALL apply together in the next cycle.
REQ-019 If SCAN_DIV = 1 or SHIFT_DIV = 1, the corresponding event SHALL occur every cycle, and shift SHALL then be held at 1.

Reset
REQ-020 While rst = 1 at a clock edge, both counters, sel and ptr SHALL be set to 0.
REQ-021 After reset the outputs SHALL be anodos = 1110, segmentos = 0x88, shift = 0.
REQ-022 Reset SHALL take priority over all counting and any pending shift event.
REQ-023 A reset asserted mid-operation SHALL take effect at the next edge, and the sequence SHALL restart identically to power-up.

Structure
REQ-024 A shared package banner_pkg SHALL hold the segment code constants and the 8-entry message ROM.
REQ-025 A sub-module tick_gen (parameter DIV; ports clk, rst, tick) SHALL implement each divider and be instantiated twice, for scan and for shift.
REQ-026 Counter widths SHALL be $clog2(DIV), with a minimum of 1 bit.

Verification (CLK_FREQ = 600, SCAN_FREQ = 60, SHIFT_FREQ = 5; SCAN_DIV = 10, SHIFT_DIV = 120; cycle 0 = first cycle after rst deasserts)
REQ-027 Reset: assert rst for 3 cycles -> anodos = 1110, segmentos = 0x88, shift = 0 throughout.
REQ-028 Scan: cycles 0-9 -> 1110/0x88; cycles 10-19 -> 1101/0xC7; cycles 20-29 -> 1011/0xC0; cycles 30-39 -> 0111/0x89; cycle 40 -> back to 1110.
REQ-029 Shift pulse: shift = 1 only in cycles 119, 239, 359, ...; each pulse is exactly 1 cycle wide.
REQ-030 Scroll: in cycles 120-129 (sel 0, ptr 1) -> segmentos = 0xFF; in cycles 150-159 (sel 3) -> segmentos = 0xC0.
REQ-031 Wrap: after 8 pulses (last at cycle 959) ptr = 0, so cycles 960-969 show 1110/0x88.
REQ-032 Mid-run reset: rst for 1 cycle at cycle 500 -> next cycle shows 1110/0x88, and the next shift pulse arrives 119 cycles after rst deasserts.
